// File: rtl/fib_seq_gen.sv
// Streams Fibonacci terms over a valid/ready handshake; stop mode ends before
// the N-bit range overflows, wrap mode emits the sequence modulo 2^N until aborted.
module fib_seq_gen #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic         abort,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic [7:0]   term_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state, state_n;
  logic [N:0]   a, a_n;
  logic [N:0]   b, b_n;
  logic [N:0]   sum;
  logic [7:0]   idx_n;
  logic         mode_q, mode_n;
  logic         fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      term_idx <= '0;
      mode_q   <= 1'b0;
    end else begin
      state    <= state_n;
      a        <= a_n;
      b        <= b_n;
      term_idx <= idx_n;
      mode_q   <= mode_n;
    end
  end

  assign sum  = a + b;
  assign fire = out_valid && out_ready;

  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    idx_n   = term_idx;
    mode_n  = mode_q;
    // abort beats both start and the handshake, so no register moves with it
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_n     = '0;
            b_n     = (N+1)'(1);
            idx_n   = '0;
            mode_n  = mode;
            state_n = EMIT;
          end
        end
        EMIT: begin
          if (fire) begin
            if (out_last) begin
              state_n = DONE;
            end else begin
              a_n   = b;
              b_n   = mode_q ? {1'b0, sum[N-1:0]} : sum;
              idx_n = term_idx + 8'd1;
            end
          end
        end
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // b[N] set means the successor of a no longer fits; gated to EMIT so it
  // never lingers once the run has finished.
  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign done      = (state == DONE);
  assign out_data  = a[N-1:0];
  assign out_last  = (state == EMIT) && !mode_q && b[N];

endmodule
